min_seq_sched: RTL and testbench

- Time-shared minimum-search sequencer. Accepts a job of LEN operands over a valid/ready stream and folds them through one registered compare/select stage.
- Returns the minimum value and its index.
- Replaces a fixed tree of min units when the operand count is variable or large. Sits between an upstream operand source and a downstream result consumer.

---
 rtl/min_seq_sched_if.sv | 39 +++
 rtl/min_seq_sched.sv | 181 ++++++++++++++++++
 tb/tb_min_seq_sched.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/min_seq_sched_if.sv
// Operand/result stream bundle for min_seq_sched.
// MIN_SEQ_MAX_EN adds the running-maximum result fields.
interface min_seq_sched_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
);
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_min;
   logic [CNT_W-1:0] out_idx;
   logic             busy;
`ifdef MIN_SEQ_MAX_EN
   logic [WIDTH-1:0] out_max;
   logic [CNT_W-1:0] out_max_idx;

   modport master (
      output start, len, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_min, out_idx, busy, out_max, out_max_idx
   );
   modport slave (
      input  start, len, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_min, out_idx, busy, out_max, out_max_idx
   );
`else
   modport master (
      output start, len, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_min, out_idx, busy
   );
   modport slave (
      input  start, len, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_min, out_idx, busy
   );
`endif
endinterface

// File: rtl/min_seq_sched.sv
// Time-shared minimum search: folds a job of len operands through one compare/select stage.
// Define MIN_SEQ_MAX_EN to also track the maximum and its index in parallel.
module min_seq_sched #(
   parameter int WIDTH = 8,
   parameter int MAX_N = 16,
   parameter int CNT_W = 5
) (
   input logic            clk,
   input logic            rst,
   min_seq_sched_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_N);
   localparam logic [WIDTH-1:0] DAT_ZERO = {WIDTH{1'b0}};

   logic [1:0]       state_r;
   logic [1:0]       state_nx_s;
   logic [CNT_W-1:0] len_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] run_min_r;
   logic [CNT_W-1:0] run_idx_r;
   logic [WIDTH-1:0] out_min_r;
   logic [CNT_W-1:0] out_idx_r;
   logic [WIDTH-1:0] cand_min_s;
   logic [CNT_W-1:0] cand_idx_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;
   logic             len_ok_s;
   logic             hs_s;
   logic             last_s;
   logic             load_s;

`ifdef MIN_SEQ_MAX_EN
   logic [WIDTH-1:0] run_max_r;
   logic [CNT_W-1:0] run_max_idx_r;
   logic [WIDTH-1:0] out_max_r;
   logic [CNT_W-1:0] out_max_idx_r;
   logic [WIDTH-1:0] cand_max_s;
   logic [CNT_W-1:0] cand_max_idx_s;
`endif

   // Handshake qualifiers and the next running-minimum candidate.
   always_comb begin
      len_ok_s = (bus.len != CNT_ZERO) && (bus.len <= CNT_MAX);
      load_s   = (state_r == ST_IDLE) && bus.start && len_ok_s;
      // in_ready_r is only ever high while accumulating.
      hs_s     = in_ready_r && bus.in_valid;
      last_s   = (cnt_r == (len_r - CNT_ONE));
      // Strict compare keeps the earliest index on ties.
      if ((cnt_r == CNT_ZERO) || (run_min_r > bus.in_data)) begin
         cand_min_s = bus.in_data;
         cand_idx_s = cnt_r;
      end else begin
         cand_min_s = run_min_r;
         cand_idx_s = run_idx_r;
      end
   end

`ifdef MIN_SEQ_MAX_EN
   // Next running-maximum candidate, same tie rule as the minimum.
   always_comb begin
      if ((cnt_r == CNT_ZERO) || (bus.in_data > run_max_r)) begin
         cand_max_s     = bus.in_data;
         cand_max_idx_s = cnt_r;
      end else begin
         cand_max_s     = run_max_r;
         cand_max_idx_s = run_max_idx_r;
      end
   end
`endif

   // Sequencer next-state decode; out_ready wins over start in DONE.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (load_s) begin
               state_nx_s = ST_ACCUM;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (hs_s && last_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_ACCUM;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= (state_nx_s == ST_ACCUM);
         out_valid_r <= (state_nx_s == ST_DONE);
         busy_r      <= (state_nx_s != ST_IDLE);
      end
   end

   // Job length, operand counter, running minimum and published result.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_r     <= CNT_ZERO;
         cnt_r     <= CNT_ZERO;
         run_min_r <= DAT_ZERO;
         run_idx_r <= CNT_ZERO;
         out_min_r <= DAT_ZERO;
         out_idx_r <= CNT_ZERO;
      end else begin
         if (load_s) begin
            len_r <= bus.len;
            cnt_r <= CNT_ZERO;
         end else if (hs_s) begin
            cnt_r     <= cnt_r + CNT_ONE;
            run_min_r <= cand_min_s;
            run_idx_r <= cand_idx_s;
         end
         // Result is published on the final handshake so it lines up with out_valid.
         if (hs_s && last_s) begin
            out_min_r <= cand_min_s;
            out_idx_r <= cand_idx_s;
         end
      end
   end

`ifdef MIN_SEQ_MAX_EN
   // Running maximum and its published result.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_max_r     <= DAT_ZERO;
         run_max_idx_r <= CNT_ZERO;
         out_max_r     <= DAT_ZERO;
         out_max_idx_r <= CNT_ZERO;
      end else begin
         if (hs_s) begin
            run_max_r     <= cand_max_s;
            run_max_idx_r <= cand_max_idx_s;
         end
         if (hs_s && last_s) begin
            out_max_r     <= cand_max_s;
            out_max_idx_r <= cand_max_idx_s;
         end
      end
   end

   assign bus.out_max     = out_max_r;
   assign bus.out_max_idx = out_max_idx_r;
`endif

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.out_min   = out_min_r;
   assign bus.out_idx   = out_idx_r;

endmodule

// File: tb/tb_min_seq_sched.sv
// Self-checking bench for min_seq_sched: vector table, directed corner sequences, random jobs vs a model.
module tb_min_seq_sched;

   typedef logic [15:0][7:0] ops_t;
   typedef struct {
      int         n;
      ops_t       ops;
      logic [7:0] emin;
      int         eidx;
      logic [7:0] emax;
      int         emaxi;
   } vec_t;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_tot;

   min_seq_sched_if #(.WIDTH(8), .CNT_W(5)) bus ();

   min_seq_sched #(.WIDTH(8), .MAX_N(16), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot = n_tot + 1;
      if (act === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model(input int n, input ops_t ops,
                                 output logic [7:0] mn, output int mi,
                                 output logic [7:0] mx, output int mxi);
      mn = ops[0]; mi = 0; mx = ops[0]; mxi = 0;
      for (int i = 1; i < n; i++) begin
         if (ops[i] < mn) begin mn = ops[i]; mi = i; end
         if (ops[i] > mx) begin mx = ops[i]; mxi = i; end
      end
   endfunction

   task automatic start_job(input int n);
      bus.start = 1'b1;
      bus.len   = 5'(n);
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_accept_busy", 32'(bus.busy), 32'd1);
   endtask

   // gap_mode: 0 back-to-back, 1 alternate idle cycle, 2 random idles; poke pulses start mid-job
   task automatic feed(input int n, input ops_t ops, input int gap_mode, input bit poke);
      for (int i = 0; i < n; i++) begin
         if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
         end
         for (int w = 0; w < 20 && !bus.in_ready; w++) @(negedge clk);
         chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b1;
         bus.in_data  = ops[i];
         if (poke && i == 1) begin
            bus.start = 1'b1;
            bus.len   = 5'd1;
         end
         @(negedge clk);
         bus.start = 1'b0;
         if (i < n - 1) chk("no_early_valid", 32'(bus.out_valid), 32'd0);
      end
      bus.in_valid = 1'b0;
      chk("out_valid_latency", 32'(bus.out_valid), 32'd1);
      chk("in_ready_done", 32'(bus.in_ready), 32'd0);
   endtask

   task automatic check_result(input logic [7:0] emin, input int eidx,
                               input logic [7:0] emax, input int emaxi);
      chk("out_min", 32'(bus.out_min), 32'(emin));
      chk("out_idx", 32'(bus.out_idx), 32'(eidx));
`ifdef MIN_SEQ_MAX_EN
      chk("out_max", 32'(bus.out_max), 32'(emax));
      chk("out_max_idx", 32'(bus.out_max_idx), 32'(emaxi));
`endif
   endtask

   task automatic consume(input logic [7:0] emin);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("consume_valid", 32'(bus.out_valid), 32'd0);
      chk("consume_busy", 32'(bus.busy), 32'd0);
      chk("consume_min_kept", 32'(bus.out_min), 32'(emin));
   endtask

   vec_t       tbl [6];
   ops_t       rops;
   logic [7:0] mn, mx;
   int         mi, mxi, rn;

   initial begin
      n_pass = 0;
      n_tot  = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.len = 5'd0; bus.in_valid = 1'b0;
      bus.in_data = 8'd0; bus.out_ready = 1'b0;

      tbl[0] = '{3, ops_t'({8'd25, 8'd12, 8'd40}), 8'd12, 1, 8'd40, 0};
      tbl[1] = '{4, ops_t'({8'd9, 8'd3, 8'd3, 8'd7}), 8'd3, 1, 8'd9, 3};
      tbl[2] = '{1, ops_t'({8'd255}), 8'd255, 0, 8'd255, 0};
      tbl[3] = '{4, ops_t'({8'd250, 8'd1, 8'd250, 8'd5}), 8'd1, 2, 8'd250, 1};
      tbl[4] = '{16, ops_t'(128'd0), 8'd1, 15, 8'd16, 0};
      for (int i = 0; i < 16; i++) tbl[4].ops[i] = 8'(16 - i);
      tbl[5] = '{16, ops_t'({16{8'hAA}}), 8'hAA, 0, 8'hAA, 0};

      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_min", 32'(bus.out_min), 32'd0);
      chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 6; t++) begin
         start_job(tbl[t].n);
         feed(tbl[t].n, tbl[t].ops, 0, 1'b0);
         check_result(tbl[t].emin, tbl[t].eidx, tbl[t].emax, tbl[t].emaxi);
         consume(tbl[t].emin);
      end

      // Illegal lengths are ignored
      bus.start = 1'b1; bus.len = 5'd0;
      @(negedge clk);
      chk("len0_busy", 32'(bus.busy), 32'd0);
      chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
      bus.len = 5'd17;
      @(negedge clk);
      bus.start = 1'b0;
      chk("len17_busy", 32'(bus.busy), 32'd0);
      chk("len17_in_ready", 32'(bus.in_ready), 32'd0);

      // Stall on both sides
      start_job(5);
      feed(5, ops_t'({8'd50, 8'd0, 8'd100, 8'd0, 8'd200}), 1, 1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_min", 32'(bus.out_min), 32'd0);
         chk("hold_idx", 32'(bus.out_idx), 32'd1);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      consume(8'd0);

      // start during ACCUM has no effect
      start_job(3);
      feed(3, ops_t'({8'd10, 8'd20, 8'd30}), 0, 1'b1);
      check_result(8'd10, 2, 8'd30, 0);
      consume(8'd10);

      // out_ready and start together in DONE: consume wins
      start_job(2);
      feed(2, ops_t'({8'd66, 8'd77}), 0, 1'b0);
      check_result(8'd66, 1, 8'd77, 0);
      bus.out_ready = 1'b1; bus.start = 1'b1; bus.len = 5'd2;
      @(negedge clk);
      bus.out_ready = 1'b0; bus.start = 1'b0;
      chk("simul_valid", 32'(bus.out_valid), 32'd0);
      chk("simul_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("simul_no_start", 32'(bus.busy), 32'd0);

      // Reset mid-job discards the partial job
      start_job(4);
      bus.in_valid = 1'b1; bus.in_data = 8'd3;
      @(negedge clk);
      bus.in_data = 8'd5;
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_out_min", 32'(bus.out_min), 32'd0);
      start_job(2);
      feed(2, ops_t'({8'd4, 8'd9}), 0, 1'b0);
      check_result(8'd4, 1, 8'd9, 0);
      consume(8'd4);

      // Random jobs against the model
      for (int j = 0; j < 30; j++) begin
         rn = $urandom_range(1, 16);
         for (int i = 0; i < 16; i++) begin
            rops[i] = (j % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         end
         model(rn, rops, mn, mi, mx, mxi);
         start_job(rn);
         feed(rn, rops, 2, 1'b0);
         check_result(mn, mi, mx, mxi);
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("rand_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("rand_hold_min", 32'(bus.out_min), 32'(mn));
         end
         consume(mn);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
